// File: rtl/slave_msg_pkg.sv
// Shared constants and types for the slave message frame parser.
// Holds the frame sync/command bytes, the parser state encoding and the BPSI record layout.
package slave_msg_pkg;

  localparam logic [7:0]  SYNC0_BYTE = 8'h55;
  localparam logic [7:0]  SYNC1_BYTE = 8'hAA;
  localparam logic [15:0] CMD_BPSI   = 16'h0001;
  localparam int          REC_BYTES  = 7;

  typedef enum logic [2:0] {
    ST_SYNC0,
    ST_SYNC1,
    ST_CMD_H,
    ST_CMD_L,
    ST_LEN_H,
    ST_LEN_L,
    ST_PAYLOAD,
    ST_CHK
  } parse_state_t;

  typedef struct packed {
    logic [1:0]  ch;
    logic [23:0] a;
    logic [23:0] b;
  } bpsi_rec_t;

endpackage

// File: rtl/slave_msg_frame_parser_if.sv
// Byte-stream input and BPSI record / status outputs of the frame parser.
// The slave modport is the parser side; the master modport drives bytes and observes results.
interface slave_msg_frame_parser_if;

  logic        msg_rx_data_vld_i;
  logic [7:0]  msg_rx_data_i;
  logic        bpsi_data_en_o;
  logic [1:0]  bpsi_ch_o;
  logic [23:0] bpsi_data_a_o;
  logic [23:0] bpsi_data_b_o;
  logic        frame_ok_o;
  logic        chk_err_o;
  logic        fmt_err_o;
  logic        timeout_o;
  logic [15:0] frame_cnt_o;
  logic [15:0] err_cnt_o;

  modport slave (
    input  msg_rx_data_vld_i, msg_rx_data_i,
    output bpsi_data_en_o, bpsi_ch_o, bpsi_data_a_o, bpsi_data_b_o,
    output frame_ok_o, chk_err_o, fmt_err_o, timeout_o, frame_cnt_o, err_cnt_o
  );

  modport master (
    output msg_rx_data_vld_i, msg_rx_data_i,
    input  bpsi_data_en_o, bpsi_ch_o, bpsi_data_a_o, bpsi_data_b_o,
    input  frame_ok_o, chk_err_o, fmt_err_o, timeout_o, frame_cnt_o, err_cnt_o
  );

endinterface

// File: rtl/slave_msg_rec_buf.sv
// Record buffer: collects the BPSI records of the frame being parsed and, once the
// frame is accepted, replays them in arrival order one per clock.
module slave_msg_rec_buf
  import slave_msg_pkg::*;
#(
  parameter int MAX_RECORDS = 8
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      wr_clr,
  input  logic      wr_en,
  input  bpsi_rec_t wr_rec,
  input  logic      drain,
  output logic      rd_en,
  output bpsi_rec_t rd_rec
);

  localparam int PTR_W = (MAX_RECORDS > 1) ? $clog2(MAX_RECORDS) : 1;
  localparam int CNT_W = $clog2(MAX_RECORDS + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX_RECORDS);

  bpsi_rec_t        mem [MAX_RECORDS];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] wr_cnt;
  logic [CNT_W-1:0] drain_cnt;
  logic             wr_ok;

  assign wr_ok = wr_en && (wr_cnt != FULL);

  // NOTE: the storage array has no reset; only the pointers and counters need a known value.
  always_ff @(posedge clk_i) begin
    if (wr_ok) mem[wr_ptr] <= wr_rec;
  end

  // Each frame writes from entry 0; the previous drain is done before the first new write.
  always_ff @(posedge clk_i) begin
    if (rst_i || wr_clr) begin
      wr_ptr <= '0;
      wr_cnt <= '0;
    end else if (wr_ok) begin
      wr_ptr <= wr_ptr + PTR_W'(1);
      wr_cnt <= wr_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_en     <= 1'b0;
      rd_rec    <= '0;
      rd_ptr    <= '0;
      drain_cnt <= '0;
    end else if (drain) begin
      rd_en     <= 1'b1;
      rd_rec    <= mem[0];
      rd_ptr    <= PTR_W'(1);
      drain_cnt <= wr_cnt - CNT_W'(1);
    end else if (drain_cnt != '0) begin
      rd_en     <= 1'b1;
      rd_rec    <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + PTR_W'(1);
      drain_cnt <= drain_cnt - CNT_W'(1);
    end else begin
      rd_en <= 1'b0;
    end
  end

endmodule

// File: rtl/slave_msg_frame_parser.sv
// Receive-side frame parser: delineates 0x55 0xAA frames, checks length, channel ids and
// XOR checksum, and replays the buffered BPSI records only for accepted frames.
module slave_msg_frame_parser
  import slave_msg_pkg::*;
#(
  parameter int MAX_RECORDS = 8,
  parameter int TIMEOUT     = 1000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  slave_msg_frame_parser_if.slave  bus
);

  localparam int          IDLE_W   = $clog2(TIMEOUT + 1);
  localparam logic [15:0] REC_LEN  = 16'(REC_BYTES);
  localparam logic [15:0] LEN_MAX  = 16'(REC_BYTES * MAX_RECORDS);
  localparam logic [2:0]  IDX_LAST = 3'(REC_BYTES - 1);

  parse_state_t      state, state_nxt;
  logic              byte_vld;
  logic [7:0]        rx_byte;
  logic [15:0]       cmd_q;
  logic [7:0]        len_h_q;
  logic [15:0]       pay_cnt;
  logic [7:0]        chk_acc;
  logic [2:0]        byte_idx;
  logic [1:0]        ch_q;
  logic [39:0]       ab_q;
  logic              bad_ch;
  logic [IDLE_W-1:0] idle_cnt;

  logic              is_bpsi;
  logic [15:0]       len_word;
  logic              len_bad;
  logic              timeout_hit;
  logic              wr_clr;
  bpsi_rec_t         rec_new;

  logic              rec_wr, ok_nxt, chk_err_nxt, fmt_err_nxt, to_nxt;
  logic              frame_ok_q, chk_err_q, fmt_err_q, timeout_q;
  logic [15:0]       frame_cnt_q, err_cnt_q;
  logic              rd_en;
  bpsi_rec_t         rd_rec;

  assign byte_vld    = bus.msg_rx_data_vld_i;
  assign rx_byte     = bus.msg_rx_data_i;
  assign is_bpsi     = (cmd_q == CMD_BPSI);
  assign len_word    = {len_h_q, rx_byte};
  assign len_bad     = is_bpsi && ((len_word == 16'd0) || ((len_word % REC_LEN) != 16'd0) ||
                                   (len_word > LEN_MAX));
  assign timeout_hit = (state != ST_SYNC0) && !byte_vld && (idle_cnt == IDLE_W'(TIMEOUT - 1));
  assign wr_clr      = byte_vld && (state == ST_LEN_L);
  // The 7th byte is b[7:0]; the previous six were captured into ch_q and ab_q.
  assign rec_new     = {ch_q, ab_q, rx_byte};

  // NOTE: sequential state uses <= so every flop samples the pre-edge values of the others.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_SYNC0;
    else       state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    if (timeout_hit) begin
      state_nxt = ST_SYNC0;
    end else if (byte_vld) begin
      case (state)
        ST_SYNC0:   if (rx_byte == SYNC0_BYTE) state_nxt = ST_SYNC1;
        ST_SYNC1:   if (rx_byte == SYNC1_BYTE)      state_nxt = ST_CMD_H;
                    else if (rx_byte != SYNC0_BYTE) state_nxt = ST_SYNC0;
        ST_CMD_H:   state_nxt = ST_CMD_L;
        ST_CMD_L:   state_nxt = ST_LEN_H;
        ST_LEN_H:   state_nxt = ST_LEN_L;
        ST_LEN_L:   if (len_bad)                  state_nxt = ST_SYNC0;
                    else if (len_word == 16'd0)   state_nxt = ST_CHK;
                    else                          state_nxt = ST_PAYLOAD;
        ST_PAYLOAD: if (pay_cnt == 16'd1) state_nxt = ST_CHK;
        ST_CHK:     state_nxt = ST_SYNC0;
        default:    state_nxt = ST_SYNC0;
      endcase
    end
  end

  always_comb begin
    rec_wr      = 1'b0;
    ok_nxt      = 1'b0;
    chk_err_nxt = 1'b0;
    fmt_err_nxt = 1'b0;
    to_nxt      = timeout_hit;
    if (byte_vld) begin
      case (state)
        ST_LEN_L:   fmt_err_nxt = len_bad;
        ST_PAYLOAD: rec_wr = is_bpsi && (byte_idx == IDX_LAST);
        ST_CHK: begin
          if (is_bpsi) begin
            if (rx_byte != chk_acc) chk_err_nxt = 1'b1;
            else if (bad_ch)        fmt_err_nxt = 1'b1;
            else                    ok_nxt      = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmd_q    <= '0;
      len_h_q  <= '0;
      pay_cnt  <= '0;
      chk_acc  <= '0;
      byte_idx <= '0;
      ch_q     <= '0;
      ab_q     <= '0;
      bad_ch   <= 1'b0;
      idle_cnt <= '0;
    end else begin
      if (byte_vld || (state == ST_SYNC0) || timeout_hit) idle_cnt <= '0;
      else                                                 idle_cnt <= idle_cnt + IDLE_W'(1);

      if (byte_vld) begin
        case (state)
          ST_SYNC1: chk_acc <= '0;
          ST_CMD_H: begin
            cmd_q[15:8] <= rx_byte;
            chk_acc     <= chk_acc ^ rx_byte;
          end
          ST_CMD_L: begin
            cmd_q[7:0] <= rx_byte;
            chk_acc    <= chk_acc ^ rx_byte;
          end
          ST_LEN_H: begin
            len_h_q <= rx_byte;
            chk_acc <= chk_acc ^ rx_byte;
          end
          ST_LEN_L: begin
            pay_cnt  <= len_word;
            byte_idx <= '0;
            bad_ch   <= 1'b0;
            chk_acc  <= chk_acc ^ rx_byte;
          end
          ST_PAYLOAD: begin
            pay_cnt  <= pay_cnt - 16'd1;
            chk_acc  <= chk_acc ^ rx_byte;
            byte_idx <= (byte_idx == IDX_LAST) ? 3'd0 : byte_idx + 3'd1;
            if (byte_idx == 3'd0) begin
              ch_q <= rx_byte[1:0];
              if (is_bpsi && (rx_byte > 8'd2)) bad_ch <= 1'b1;
            end else begin
              ab_q <= {ab_q[31:0], rx_byte};
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_ok_q  <= 1'b0;
      chk_err_q   <= 1'b0;
      fmt_err_q   <= 1'b0;
      timeout_q   <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      frame_ok_q <= ok_nxt;
      chk_err_q  <= chk_err_nxt;
      fmt_err_q  <= fmt_err_nxt;
      timeout_q  <= to_nxt;
      if (ok_nxt) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (chk_err_nxt || fmt_err_nxt || to_nxt) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  slave_msg_rec_buf #(
    .MAX_RECORDS(MAX_RECORDS)
  ) u_rec_buf (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .wr_clr (wr_clr),
    .wr_en  (rec_wr),
    .wr_rec (rec_new),
    .drain  (ok_nxt),
    .rd_en  (rd_en),
    .rd_rec (rd_rec)
  );

  assign bus.bpsi_data_en_o = rd_en;
  assign bus.bpsi_ch_o      = rd_rec.ch;
  assign bus.bpsi_data_a_o  = rd_rec.a;
  assign bus.bpsi_data_b_o  = rd_rec.b;
  assign bus.frame_ok_o     = frame_ok_q;
  assign bus.chk_err_o      = chk_err_q;
  assign bus.fmt_err_o      = fmt_err_q;
  assign bus.timeout_o      = timeout_q;
  assign bus.frame_cnt_o    = frame_cnt_q;
  assign bus.err_cnt_o      = err_cnt_q;

endmodule

// File: tb/tb_slave_msg_frame_parser.sv
// Bench for slave_msg_frame_parser: builds frames byte by byte, queues the records each
// accepted frame must replay, and compares them as they appear on the record strobe.
module tb_slave_msg_frame_parser;
  import slave_msg_pkg::*;

  localparam int MAX_REC = 8;
  localparam int TMO     = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  slave_msg_frame_parser_if bus();

  slave_msg_frame_parser #(
    .MAX_RECORDS(MAX_REC),
    .TIMEOUT    (TMO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int n_pass = 0;
  int n_total = 0;
  int rec_seen = 0;
  int ok_seen = 0;
  int exp_frames = 0;
  int exp_errs = 0;

  logic [7:0] pay_q[$];
  logic [7:0] tx_q[$];
  bpsi_rec_t  pend_q[$];
  bpsi_rec_t  exp_q[$];

  // Scoreboard: every strobed record must be the oldest outstanding expected record.
  always @(negedge clk) begin
    bpsi_rec_t got, want;
    if (!rst && bus.frame_ok_o) ok_seen++;
    if (!rst && bus.bpsi_data_en_o) begin
      rec_seen++;
      n_total++;
      got = {bus.bpsi_ch_o, bus.bpsi_data_a_o, bus.bpsi_data_b_o};
      if (exp_q.size() == 0) begin
        $display("FAIL record_unexpected: got ch=%0d a=%06h b=%06h, required no record",
                 got.ch, got.a, got.b);
      end else begin
        want = exp_q.pop_front();
        if (got !== want)
          $display("FAIL record_data: got ch=%0d a=%06h b=%06h, required ch=%0d a=%06h b=%06h",
                   got.ch, got.a, got.b, want.ch, want.a, want.b);
        else n_pass++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic add_rec(input logic [7:0] ch, input logic [23:0] a, input logic [23:0] b);
    bpsi_rec_t r;
    pay_q.push_back(ch);
    pay_q.push_back(a[23:16]); pay_q.push_back(a[15:8]); pay_q.push_back(a[7:0]);
    pay_q.push_back(b[23:16]); pay_q.push_back(b[15:8]); pay_q.push_back(b[7:0]);
    r = {ch[1:0], a, b};
    pend_q.push_back(r);
  endtask

  task automatic build_frame(input logic [15:0] cmd, input logic [15:0] len,
                             input logic [7:0] flip, input bit hdr_only);
    logic [7:0] x;
    x = cmd[15:8] ^ cmd[7:0] ^ len[15:8] ^ len[7:0];
    tx_q.push_back(8'h55); tx_q.push_back(8'hAA);
    tx_q.push_back(cmd[15:8]); tx_q.push_back(cmd[7:0]);
    tx_q.push_back(len[15:8]); tx_q.push_back(len[7:0]);
    if (!hdr_only) begin
      foreach (pay_q[i]) begin
        tx_q.push_back(pay_q[i]);
        x = x ^ pay_q[i];
      end
      tx_q.push_back(x ^ flip);
    end
    pay_q.delete();
  endtask

  task automatic commit_pending();
    foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
    pend_q.delete();
  endtask

  // Returns at the falling edge one cycle after the last byte was accepted.
  task automatic send_tx();
    foreach (tx_q[i]) begin
      @(negedge clk);
      bus.msg_rx_data_vld_i = 1'b1;
      bus.msg_rx_data_i     = tx_q[i];
    end
    tx_q.delete();
    @(negedge clk);
    bus.msg_rx_data_vld_i = 1'b0;
    bus.msg_rx_data_i     = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_good(input int n, input string tag);
    for (int i = 0; i < n; i++) add_rec(8'(i % 3), 24'($urandom), 24'($urandom));
    build_frame(16'h0001, 16'(7 * n), 8'h00, 1'b0);
    commit_pending();
    send_tx();
    exp_frames++;
    n_total++;
    if (bus.frame_ok_o !== 1'b1) $display("FAIL %s_frame_ok: got %b required 1", tag, bus.frame_ok_o);
    else n_pass++;
    n_total++;
    if (bus.frame_cnt_o !== 16'(exp_frames))
      $display("FAIL %s_frame_cnt: got %0d required %0d", tag, bus.frame_cnt_o, exp_frames);
    else n_pass++;
    idle(n + 2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    n_total++;
    if ({bus.bpsi_data_en_o, bus.bpsi_ch_o, bus.bpsi_data_a_o, bus.bpsi_data_b_o} !== 51'd0)
      $display("FAIL reset_record_outputs: got en=%b ch=%0d a=%06h b=%06h required all 0",
               bus.bpsi_data_en_o, bus.bpsi_ch_o, bus.bpsi_data_a_o, bus.bpsi_data_b_o);
    else n_pass++;
    n_total++;
    if ({bus.frame_ok_o, bus.chk_err_o, bus.fmt_err_o, bus.timeout_o} !== 4'b0000)
      $display("FAIL reset_pulses: got %b required 0000",
               {bus.frame_ok_o, bus.chk_err_o, bus.fmt_err_o, bus.timeout_o});
    else n_pass++;
    n_total++;
    if ({bus.frame_cnt_o, bus.err_cnt_o} !== 32'd0)
      $display("FAIL reset_counters: got frame=%0d err=%0d required 0/0", bus.frame_cnt_o, bus.err_cnt_o);
    else n_pass++;
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_good_frame();
    add_rec(8'd0, 24'h010203, 24'h111213);
    add_rec(8'd1, 24'h040506, 24'h141516);
    add_rec(8'd2, 24'h070809, 24'h171819);
    build_frame(16'h0001, 16'd21, 8'h00, 1'b0);
    commit_pending();
    send_tx();
    exp_frames++;
    n_total++;
    if ({bus.frame_ok_o, bus.chk_err_o, bus.fmt_err_o, bus.bpsi_data_en_o} !== 4'b1001)
      $display("FAIL good_pulses_t1: got ok/chk/fmt/en=%b required 1001",
               {bus.frame_ok_o, bus.chk_err_o, bus.fmt_err_o, bus.bpsi_data_en_o});
    else n_pass++;
    n_total++;
    if (bus.frame_cnt_o !== 16'd1) $display("FAIL good_frame_cnt: got %0d required 1", bus.frame_cnt_o);
    else n_pass++;
    idle(1);
    n_total++;
    if ({bus.frame_ok_o, bus.bpsi_data_en_o} !== 2'b01)
      $display("FAIL good_t2: got ok/en=%b required 01", {bus.frame_ok_o, bus.bpsi_data_en_o});
    else n_pass++;
    idle(1);
    n_total++;
    if (bus.bpsi_data_en_o !== 1'b1) $display("FAIL good_t3_en: got %b required 1", bus.bpsi_data_en_o);
    else n_pass++;
    idle(1);
    n_total++;
    if ({bus.bpsi_data_en_o, bus.bpsi_data_a_o, bus.bpsi_data_b_o} !== {1'b0, 24'h070809, 24'h171819})
      $display("FAIL good_hold: got en=%b a=%06h b=%06h required en=0 a=070809 b=171819",
               bus.bpsi_data_en_o, bus.bpsi_data_a_o, bus.bpsi_data_b_o);
    else n_pass++;
    n_total++;
    if (exp_q.size() != 0) $display("FAIL good_drained: got %0d left required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_chk_err();
    int r0;
    r0 = rec_seen;
    add_rec(8'd0, 24'h010203, 24'h111213);
    add_rec(8'd1, 24'h040506, 24'h141516);
    add_rec(8'd2, 24'h070809, 24'h171819);
    pend_q.delete();
    build_frame(16'h0001, 16'd21, 8'h01, 1'b0);
    send_tx();
    exp_errs++;
    n_total++;
    if ({bus.frame_ok_o, bus.chk_err_o, bus.fmt_err_o} !== 3'b010)
      $display("FAIL chk_pulses: got ok/chk/fmt=%b required 010",
               {bus.frame_ok_o, bus.chk_err_o, bus.fmt_err_o});
    else n_pass++;
    n_total++;
    if (bus.err_cnt_o !== 16'(exp_errs)) $display("FAIL chk_err_cnt: got %0d required %0d", bus.err_cnt_o, exp_errs);
    else n_pass++;
    idle(6);
    n_total++;
    if (rec_seen != r0) $display("FAIL chk_no_records: got %0d records required 0", rec_seen - r0);
    else n_pass++;
  endtask

  task automatic test_bad_len(input logic [15:0] len, input string tag);
    build_frame(16'h0001, len, 8'h00, 1'b1);
    send_tx();
    exp_errs++;
    n_total++;
    if ({bus.frame_ok_o, bus.chk_err_o, bus.fmt_err_o} !== 3'b001)
      $display("FAIL %s_pulses: got ok/chk/fmt=%b required 001", tag,
               {bus.frame_ok_o, bus.chk_err_o, bus.fmt_err_o});
    else n_pass++;
    n_total++;
    if (bus.err_cnt_o !== 16'(exp_errs)) $display("FAIL %s_err_cnt: got %0d required %0d", tag, bus.err_cnt_o, exp_errs);
    else n_pass++;
    send_good(2, {tag, "_resync"});
  endtask

  task automatic test_resync_and_other();
    int k0;
    tx_q.push_back(8'h55);
    add_rec(8'd2, 24'hABCDEF, 24'h123456);
    build_frame(16'h0001, 16'd7, 8'h00, 1'b0);
    commit_pending();
    send_tx();
    exp_frames++;
    n_total++;
    if (bus.frame_ok_o !== 1'b1) $display("FAIL resync_frame_ok: got %b required 1", bus.frame_ok_o);
    else n_pass++;
    idle(3);
    k0 = ok_seen;
    pay_q.push_back(8'h55); pay_q.push_back(8'h03); pay_q.push_back(8'hC7);
    build_frame(16'h0002, 16'd3, 8'h00, 1'b0);
    send_tx();
    idle(3);
    n_total++;
    if ({ok_seen - k0, 32'(bus.err_cnt_o)} !== {32'd0, 32'(exp_errs)})
      $display("FAIL other_cmd_silent: got ok=%0d err_cnt=%0d required 0/%0d",
               ok_seen - k0, bus.err_cnt_o, exp_errs);
    else n_pass++;
    send_good(1, "after_other");
  endtask

  task automatic test_bad_ch();
    int r0;
    r0 = rec_seen;
    add_rec(8'd3, 24'h000001, 24'h000002);
    add_rec(8'd0, 24'h000003, 24'h000004);
    pend_q.delete();
    build_frame(16'h0001, 16'd14, 8'h00, 1'b0);
    send_tx();
    exp_errs++;
    n_total++;
    if ({bus.frame_ok_o, bus.chk_err_o, bus.fmt_err_o} !== 3'b001)
      $display("FAIL bad_ch_pulses: got ok/chk/fmt=%b required 001",
               {bus.frame_ok_o, bus.chk_err_o, bus.fmt_err_o});
    else n_pass++;
    idle(5);
    n_total++;
    if (rec_seen != r0) $display("FAIL bad_ch_no_records: got %0d records required 0", rec_seen - r0);
    else n_pass++;
  endtask

  task automatic test_timeout();
    add_rec(8'd1, 24'h0A0B0C, 24'h0D0E0F);
    pend_q.delete();
    build_frame(16'h0001, 16'd7, 8'h00, 1'b0);
    while (tx_q.size() > 10) void'(tx_q.pop_back());
    send_tx();
    exp_errs++;
    for (int k = 2; k <= TMO + 1; k++) begin
      idle(1);
      if (k == TMO) begin
        n_total++;
        if (bus.timeout_o !== 1'b0) $display("FAIL timeout_early: got %b at %0d required 0", bus.timeout_o, k);
        else n_pass++;
      end
    end
    n_total++;
    if (bus.timeout_o !== 1'b1) $display("FAIL timeout_pulse: got %b required 1", bus.timeout_o);
    else n_pass++;
    n_total++;
    if (bus.err_cnt_o !== 16'(exp_errs)) $display("FAIL timeout_err_cnt: got %0d required %0d", bus.err_cnt_o, exp_errs);
    else n_pass++;
    idle(1);
    send_good(3, "after_timeout");
  endtask

  task automatic test_back_to_back();
    int r0, k0;
    r0 = rec_seen;
    k0 = ok_seen;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < MAX_REC; i++) add_rec(8'(i % 3), 24'($urandom), 24'($urandom));
      build_frame(16'h0001, 16'(7 * MAX_REC), 8'h00, 1'b0);
    end
    commit_pending();
    send_tx();
    exp_frames += 2;
    idle(12);
    n_total++;
    if (rec_seen - r0 != 2 * MAX_REC)
      $display("FAIL b2b_record_count: got %0d required %0d", rec_seen - r0, 2 * MAX_REC);
    else n_pass++;
    n_total++;
    if ({ok_seen - k0, 32'(bus.frame_cnt_o)} !== {32'd2, 32'(exp_frames)})
      $display("FAIL b2b_frames: got ok=%0d cnt=%0d required 2/%0d", ok_seen - k0, bus.frame_cnt_o, exp_frames);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int r0;
    add_rec(8'd0, 24'h111111, 24'h222222);
    add_rec(8'd1, 24'h333333, 24'h444444);
    pend_q.delete();
    build_frame(16'h0001, 16'd14, 8'h00, 1'b0);
    while (tx_q.size() > 16) void'(tx_q.pop_back());
    send_tx();
    rst = 1'b1;
    idle(2);
    n_total++;
    if ({bus.bpsi_data_en_o, bus.bpsi_data_a_o, bus.bpsi_data_b_o, bus.frame_cnt_o, bus.err_cnt_o} !== 81'd0)
      $display("FAIL mid_reset_outputs: got en=%b a=%06h b=%06h frame=%0d err=%0d required all 0",
               bus.bpsi_data_en_o, bus.bpsi_data_a_o, bus.bpsi_data_b_o, bus.frame_cnt_o, bus.err_cnt_o);
    else n_pass++;
    rst = 1'b0;
    exp_frames = 0;
    exp_errs = 0;
    r0 = rec_seen;
    idle(TMO + 5);
    n_total++;
    if (rec_seen != r0) $display("FAIL mid_reset_no_records: got %0d required 0", rec_seen - r0);
    else n_pass++;
    send_good(2, "after_reset");
  endtask

  initial begin
    bus.msg_rx_data_vld_i = 1'b0;
    bus.msg_rx_data_i     = 8'h00;
    test_reset();
    test_good_frame();
    test_chk_err();
    test_bad_len(16'd8, "len8");
    test_bad_len(16'd63, "len63");
    test_resync_and_other();
    test_bad_ch();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    idle(4);
    n_total++;
    if (exp_q.size() != 0) $display("FAIL final_scoreboard: got %0d pending required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
